avalon_rr_arbiter2: RTL and testbench

Two-master, one-slave round-robin arbiter for the 30-bit word-addressed burst bus used by the FPGA memory slaves. It grants the shared slave port to one master for an entire burst, forwards the command exactly once, and routes the read/write beats back to the owner. It releases the grant after the last beat, or on a timeout if no slave answers. It sits between the CPU-side masters (e.g. instruction fetch and data port) and the memory/peripheral slave fabric.

---
 rtl/avalon_rr_arbiter2.sv | 174 +++++++++++++++++
 tb/tb_avalon_rr_arbiter2.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_rr_arbiter2.sv
// Two-master round-robin arbiter for the word-addressed burst bus.
// Holds the grant for a whole burst and ends unanswered bursts with a single error beat.
module avalon_rr_arbiter2 #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  m0_burstcount,
    input  logic [31:0] m0_writedata,
    input  logic [29:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [3:0]  m0_byteenable,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    output logic        m0_readdatavalid,
    output logic        m0_writeresponsevalid,
    output logic [1:0]  m0_response,
    input  logic [4:0]  m1_burstcount,
    input  logic [31:0] m1_writedata,
    input  logic [29:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [3:0]  m1_byteenable,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic        m1_readdatavalid,
    output logic        m1_writeresponsevalid,
    output logic [1:0]  m1_response,
    output logic [4:0]  s_burstcount,
    output logic [31:0] s_writedata,
    output logic [29:0] s_address,
    output logic [3:0]  s_byteenable,
    output logic        s_read,
    output logic        s_write,
    input  logic        s_waitrequest,
    input  logic [31:0] s_readdata,
    input  logic        s_readdatavalid,
    input  logic        s_writeresponsevalid,
    input  logic [1:0]  s_response
);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_owner_q, last_owner_d;
    logic             cmd_done_q, cmd_done_d;
    logic             rd_n_wr_q, rd_n_wr_d;
    logic [4:0]       beats_left_q, beats_left_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Owner-side return path before steering to m0/m1
    logic        o_wait, o_rdv, o_wrv;
    logic [31:0] o_rdata;
    logic [1:0]  o_resp;

    logic        req0, req1, gnt, beat, cmd_accept, tmo_hit;
    logic [4:0]  gnt_burstcount;
    logic        own_read, own_write;

    assign req0           = m0_read | m0_write;
    assign req1           = m1_read | m1_write;
    assign gnt            = (req0 & req1) ? ~last_owner_q : req1;
    assign gnt_burstcount = gnt ? m1_burstcount : m0_burstcount;
    assign own_read       = owner_q ? m1_read : m0_read;
    assign own_write      = owner_q ? m1_write : m0_write;
    assign beat           = s_readdatavalid | s_writeresponsevalid;
    assign cmd_accept     = (own_read | own_write) & ~cmd_done_q & ~s_waitrequest;
    assign tmo_hit        = ~beat & (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES));

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            cmd_done_q   <= 1'b0;
            rd_n_wr_q    <= 1'b0;
            beats_left_q <= '0;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cmd_done_q   <= cmd_done_d;
            rd_n_wr_q    <= rd_n_wr_d;
            beats_left_q <= beats_left_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    // Next-state and bus steering
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cmd_done_d   = cmd_done_q;
        rd_n_wr_d    = rd_n_wr_q;
        beats_left_d = beats_left_q;
        tmo_cnt_d    = tmo_cnt_q;
        s_burstcount = '0;
        s_writedata  = '0;
        s_address    = '0;
        s_byteenable = '0;
        s_read       = 1'b0;
        s_write      = 1'b0;
        o_wait       = 1'b1;
        o_rdata      = '0;
        o_rdv        = 1'b0;
        o_wrv        = 1'b0;
        o_resp       = '0;

        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    owner_d      = gnt;
                    beats_left_d = (gnt_burstcount == 5'd0) ? 5'd1 : gnt_burstcount;
                    rd_n_wr_d    = gnt ? m1_read : m0_read;
                    cmd_done_d   = 1'b0;
                    tmo_cnt_d    = '0;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                s_burstcount = owner_q ? m1_burstcount : m0_burstcount;
                s_writedata  = owner_q ? m1_writedata  : m0_writedata;
                s_address    = owner_q ? m1_address    : m0_address;
                s_byteenable = owner_q ? m1_byteenable : m0_byteenable;
                s_read       = own_read & ~cmd_done_q;
                s_write      = own_write & ~cmd_done_q;
                o_wait       = cmd_done_q ? 1'b1 : s_waitrequest;
                o_rdata      = s_readdata;
                o_rdv        = s_readdatavalid;
                o_wrv        = s_writeresponsevalid;
                o_resp       = s_response;
                if (cmd_accept) begin
                    cmd_done_d = 1'b1;
                end
                if (beat) begin
                    beats_left_d = beats_left_q - 5'd1;
                    tmo_cnt_d    = '0;
                    if (beats_left_q == 5'd1) begin
                        state_d      = IDLE;
                        last_owner_d = owner_q;
                    end
                end else if (tmo_hit) begin
                    // Synthesised error beat; the rest of the burst is abandoned
                    o_rdata    = '0;
                    o_rdv      = rd_n_wr_q;
                    o_wrv      = ~rd_n_wr_q;
                    o_resp     = RESP_DECERR;
                    cmd_done_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
        endcase

        m0_waitrequest        = owner_q ? 1'b1 : o_wait;
        m0_readdata           = owner_q ? '0   : o_rdata;
        m0_readdatavalid      = owner_q ? 1'b0 : o_rdv;
        m0_writeresponsevalid = owner_q ? 1'b0 : o_wrv;
        m0_response           = owner_q ? '0   : o_resp;
        m1_waitrequest        = owner_q ? o_wait  : 1'b1;
        m1_readdata           = owner_q ? o_rdata : '0;
        m1_readdatavalid      = owner_q ? o_rdv   : 1'b0;
        m1_writeresponsevalid = owner_q ? o_wrv   : 1'b0;
        m1_response           = owner_q ? o_resp  : '0;
    end
endmodule

// File: tb/tb_avalon_rr_arbiter2.sv
// Directed bench for avalon_rr_arbiter2: single read, bursts, contention, timeout,
// zero burstcount and mid-burst reset, checked with immediate assertions.
module tb_avalon_rr_arbiter2;
    localparam int unsigned TMO = 64;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  m0_burstcount, m1_burstcount, s_burstcount;
    logic [31:0] m0_writedata, m1_writedata, s_writedata;
    logic [29:0] m0_address, m1_address, s_address;
    logic        m0_read, m0_write, m1_read, m1_write, s_read, s_write;
    logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
    logic        m0_waitrequest, m1_waitrequest, s_waitrequest;
    logic [31:0] m0_readdata, m1_readdata, s_readdata;
    logic        m0_readdatavalid, m1_readdatavalid, s_readdatavalid;
    logic        m0_writeresponsevalid, m1_writeresponsevalid, s_writeresponsevalid;
    logic [1:0]  m0_response, m1_response, s_response;

    int total = 0;
    int bad   = 0;
    logic [31:0] wdata [4];

    avalon_rr_arbiter2 #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_burstcount(m0_burstcount), .m0_writedata(m0_writedata), .m0_address(m0_address),
        .m0_read(m0_read), .m0_write(m0_write), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid), .m0_writeresponsevalid(m0_writeresponsevalid),
        .m0_response(m0_response),
        .m1_burstcount(m1_burstcount), .m1_writedata(m1_writedata), .m1_address(m1_address),
        .m1_read(m1_read), .m1_write(m1_write), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid), .m1_writeresponsevalid(m1_writeresponsevalid),
        .m1_response(m1_response),
        .s_burstcount(s_burstcount), .s_writedata(s_writedata), .s_address(s_address),
        .s_byteenable(s_byteenable), .s_read(s_read), .s_write(s_write),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid), .s_writeresponsevalid(s_writeresponsevalid),
        .s_response(s_response)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here, checks #1 later
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        m0_burstcount = '0; m0_writedata = '0; m0_address = '0;
        m0_read = 1'b0; m0_write = 1'b0; m0_byteenable = '0;
        m1_burstcount = '0; m1_writedata = '0; m1_address = '0;
        m1_read = 1'b0; m1_write = 1'b0; m1_byteenable = '0;
        s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;
        s_writeresponsevalid = 1'b0; s_response = '0;
    endtask

    initial begin
        int tmo_at;
        logic own;
        wdata[0] = 32'h1111_0001; wdata[1] = 32'h2222_0002;
        wdata[2] = 32'h3333_0003; wdata[3] = 32'h4444_0004;
        clear_inputs();
        rst_i = 1'b1;
        cyc(); cyc();
        rst_i = 1'b0;

        // Reset state; a stray slave beat in IDLE is dropped
        s_readdatavalid = 1'b1;
        #1;
        chk1("rst_m0_wait", m0_waitrequest, 1'b1);
        chk1("rst_m1_wait", m1_waitrequest, 1'b1);
        chk1("rst_s_read", s_read, 1'b0);
        chk1("rst_s_write", s_write, 1'b0);
        chk32("rst_s_addr", 32'(s_address), 32'h0);
        chk1("idle_drop_rdv", m0_readdatavalid, 1'b0);
        s_readdatavalid = 1'b0;

        // Single read by m0
        cyc();
        m0_read = 1'b1; m0_address = 30'h100; m0_burstcount = 5'd1; m0_byteenable = 4'hF;
        #1;
        chk1("rd1_idle_s_read", s_read, 1'b0);
        chk1("rd1_idle_wait", m0_waitrequest, 1'b1);
        cyc();
        #1;
        chk1("rd1_s_read", s_read, 1'b1);
        chk32("rd1_s_addr", 32'(s_address), 32'h100);
        chk1("rd1_accept_wait", m0_waitrequest, 1'b0);
        chk1("rd1_m1_wait", m1_waitrequest, 1'b1);
        cyc();
        m0_read = 1'b0;
        s_readdatavalid = 1'b1; s_readdata = 32'hCAFE_F00D;
        #1;
        chk1("rd1_s_read_masked", s_read, 1'b0);
        chk1("rd1_rdv", m0_readdatavalid, 1'b1);
        chk32("rd1_data", m0_readdata, 32'hCAFE_F00D);
        chk32("rd1_resp", 32'(m0_response), 32'h0);
        chk1("rd1_m1_rdv", m1_readdatavalid, 1'b0);
        chk32("rd1_m1_data", m1_readdata, 32'h0);
        cyc();
        s_readdata = 32'hDEAD_BEEF;
        #1;
        chk1("rd1_released", m0_readdatavalid, 1'b0);
        chk1("rd1_idle_wait2", m0_waitrequest, 1'b1);
        s_readdatavalid = 1'b0; s_readdata = '0;

        // Burst write by m1, slave stalls acceptance one cycle, beat in acceptance cycle
        cyc();
        m1_write = 1'b1; m1_address = 30'h200; m1_burstcount = 5'd4; m1_byteenable = 4'hF;
        m1_writedata = wdata[0]; s_waitrequest = 1'b1;
        cyc();
        #1;
        chk1("wr_s_write", s_write, 1'b1);
        chk32("wr_s_bc", 32'(s_burstcount), 32'd4);
        chk1("wr_stall_wait", m1_waitrequest, 1'b1);
        chk1("wr_m0_wait", m0_waitrequest, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 0) s_waitrequest = 1'b0;
            else m1_write = 1'b0;
            m1_writedata = wdata[i];
            s_writeresponsevalid = 1'b1;
            #1;
            chk1("wr_s_write_until_accept", s_write, i == 0);
            chk32("wr_s_wdata", s_writedata, wdata[i]);
            chk1("wr_wrv", m1_writeresponsevalid, 1'b1);
            chk1("wr_m0_wrv", m0_writeresponsevalid, 1'b0);
        end
        cyc();
        #1;
        chk1("wr_released", m1_writeresponsevalid, 1'b0);
        chk1("wr_idle_wait", m1_waitrequest, 1'b1);
        s_writeresponsevalid = 1'b0;

        // Read-back burst by m1
        m1_read = 1'b1; m1_burstcount = 5'd4;
        cyc();
        #1;
        chk1("rb_s_read", s_read, 1'b1);
        chk32("rb_s_addr", 32'(s_address), 32'h200);
        for (int i = 0; i < 4; i++) begin
            cyc();
            m1_read = 1'b0;
            s_readdatavalid = 1'b1; s_readdata = wdata[i];
            #1;
            chk1("rb_rdv", m1_readdatavalid, 1'b1);
            chk32("rb_data", m1_readdata, wdata[i]);
        end
        cyc();
        s_readdatavalid = 1'b0; s_readdata = '0;

        // Contention: both masters hold 2-beat read requests
        m0_read = 1'b1; m0_address = 30'h300; m0_burstcount = 5'd2;
        m1_read = 1'b1; m1_address = 30'h400; m1_burstcount = 5'd2;
        for (int k = 0; k < 4; k++) begin
            own = 1'(k % 2);
            #1;
            chk1("ct_gap_s_read", s_read, 1'b0);
            chk1("ct_gap_m0_wait", m0_waitrequest, 1'b1);
            chk1("ct_gap_m1_wait", m1_waitrequest, 1'b1);
            cyc();
            #1;
            chk1("ct_s_read", s_read, 1'b1);
            chk32("ct_s_addr", 32'(s_address), own ? 32'h400 : 32'h300);
            chk1("ct_m0_wait", m0_waitrequest, own);
            chk1("ct_m1_wait", m1_waitrequest, ~own);
            for (int b = 0; b < 2; b++) begin
                cyc();
                s_readdatavalid = 1'b1; s_readdata = 32'hA000_0000 + 32'(k * 2 + b);
                #1;
                chk1("ct_m0_rdv", m0_readdatavalid, ~own);
                chk1("ct_m1_rdv", m1_readdatavalid, own);
                chk32("ct_owner_data", own ? m1_readdata : m0_readdata,
                      32'hA000_0000 + 32'(k * 2 + b));
            end
            cyc();
            s_readdatavalid = 1'b0; s_readdata = '0;
        end
        m0_read = 1'b0; m1_read = 1'b0;
        cyc();

        // Timeout: unmapped address, slave accepts but never answers
        m0_read = 1'b1; m0_address = 30'h3FFF_FFF0; m0_burstcount = 5'd1;
        cyc();
        #1;
        chk1("to_s_read", s_read, 1'b1);
        chk1("to_accept_wait", m0_waitrequest, 1'b0);
        cyc();
        m0_read = 1'b0;
        tmo_at = 0;
        for (int j = 1; j <= int'(TMO) + 16 && tmo_at == 0; j++) begin
            #1;
            if (m0_readdatavalid) tmo_at = j;
            else cyc();
        end
        chk32("to_cycle", 32'(tmo_at), 32'(TMO));
        chk32("to_resp", 32'(m0_response), 32'h3);
        chk32("to_data", m0_readdata, 32'h0);
        chk1("to_wrv", m0_writeresponsevalid, 1'b0);
        chk1("to_m1_rdv", m1_readdatavalid, 1'b0);

        // Next request after the timeout is served normally
        cyc();
        m0_read = 1'b1; m0_address = 30'h10; m0_burstcount = 5'd1;
        #1;
        chk1("to_single_err_beat", m0_readdatavalid, 1'b0);
        chk1("to_idle_wait", m0_waitrequest, 1'b1);
        cyc();
        #1;
        chk32("post_to_s_addr", 32'(s_address), 32'h10);
        chk1("post_to_wait", m0_waitrequest, 1'b0);
        cyc();
        m0_read = 1'b0;
        s_readdatavalid = 1'b1; s_readdata = 32'h1234_5678;
        #1;
        chk32("post_to_data", m0_readdata, 32'h1234_5678);
        chk32("post_to_resp", 32'(m0_response), 32'h0);
        cyc();
        s_readdatavalid = 1'b0; s_readdata = '0;

        // Zero burstcount write by m1 counts as one beat
        m1_write = 1'b1; m1_address = 30'h220; m1_burstcount = 5'd0; m1_writedata = 32'h5A5A_5A5A;
        cyc();
        #1;
        chk1("zb_s_write", s_write, 1'b1);
        chk1("zb_accept_wait", m1_waitrequest, 1'b0);
        cyc();
        m1_write = 1'b0;
        s_writeresponsevalid = 1'b1;
        #1;
        chk1("zb_wrv", m1_writeresponsevalid, 1'b1);
        cyc();
        #1;
        chk1("zb_released", m1_writeresponsevalid, 1'b0);
        chk1("zb_s_write_idle", s_write, 1'b0);
        s_writeresponsevalid = 1'b0;
        cyc();

        // Reset during beat 2 of a 4-beat m1 read
        m1_read = 1'b1; m1_address = 30'h500; m1_burstcount = 5'd4;
        cyc();
        #1;
        chk1("rs_s_read", s_read, 1'b1);
        cyc();
        m1_read = 1'b0;
        s_readdatavalid = 1'b1; s_readdata = 32'hB000_0001;
        cyc();
        s_readdata = 32'hB000_0002; rst_i = 1'b1;
        #1;
        chk1("rs_beat2_rdv", m1_readdatavalid, 1'b1);
        cyc();
        rst_i = 1'b0;
        s_readdata = 32'hB000_0003;
        m0_read = 1'b1; m0_address = 30'h600; m0_burstcount = 5'd1;
        m1_read = 1'b1; m1_address = 30'h700; m1_burstcount = 5'd1;
        #1;
        chk1("rs_m1_rdv", m1_readdatavalid, 1'b0);
        chk32("rs_m1_resp", 32'(m1_response), 32'h0);
        chk1("rs_m0_rdv", m0_readdatavalid, 1'b0);
        chk1("rs_m0_wait", m0_waitrequest, 1'b1);
        chk1("rs_m1_wait", m1_waitrequest, 1'b1);
        chk1("rs_s_read", s_read, 1'b0);
        chk1("rs_s_write", s_write, 1'b0);
        cyc();
        s_readdatavalid = 1'b0;
        #1;
        chk32("rs_grant_addr", 32'(s_address), 32'h600);
        chk1("rs_grant_m0_wait", m0_waitrequest, 1'b0);
        chk1("rs_grant_m1_wait", m1_waitrequest, 1'b1);
        clear_inputs();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
